// File: rtl/ps2kb_responder.sv
// ps2kb_responder
//   PS/2 keyboard receiver for the 4'hd bus window. It receives device-to-host
//   frames, folds the F0 break prefix into the following scan code, drops the
//   E0 extension prefix, and queues {break, scan} events in a small FIFO.
//   The FIFO head is presented to the bus and popped when a read access ends.
// Ports
//   clk        system clock, all state changes on posedge
//   rst_n      asynchronous active-low reset
//   ps2_clk    PS/2 clock pad (asynchronous)
//   ps2_data   PS/2 data pad (asynchronous)
//   ps2kb_rd   bus read strobe, high for the whole read access
//   ps2kb_key  {valid, break, scan[7:0]} of the FIFO head, zero when empty
//   ps2kb_ovf  sticky flag: a complete key event was dropped on a full FIFO
//   ps2kb_err  saturating count of parity, framing and timeout errors
module ps2kb_responder #(
  parameter int FIFO_AW     = 3,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ps2kb_rd,
  output logic [9:0] ps2kb_key,
  output logic       ps2kb_ovf,
  output logic [7:0] ps2kb_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [FIFO_AW:0] CNT_FULL  = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // Registered state
  logic [1:0]         clk_s_q, dat_s_q;
  logic               filt_q, filt_d, filt_prev_q;
  logic [FW-1:0]      filt_cnt_q, filt_cnt_d;
  state_e             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_q, par_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic               break_pend_q, break_pend_d;
  logic [7:0]         err_q, err_d;
  logic               ovf_q, ovf_d;
  logic               rd_q;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [8:0]         mem [DEPTH];

  // Combinational helpers
  logic fall, din, push_req, err_inc, empty, full, push, pop;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    filt_d       = filt_q;
    filt_cnt_d   = '0;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tmo_cnt_d    = tmo_cnt_q;
    break_pend_d = break_pend_q;
    push_req     = 1'b0;
    err_inc      = 1'b0;

    // Glitch filter: the raw level must differ for FILTER_LEN consecutive
    // cycles before the filtered copy follows it.
    if (clk_s_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_LAST) filt_d = clk_s_q[1];
      else                         filt_cnt_d = filt_cnt_q + FW'(1);
    end

    fall = filt_prev_q & ~filt_q;
    din  = dat_s_q[1];

    if (fall) begin
      tmo_cnt_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (!din) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d = {din, shift_q[7:1]};  // LSB arrives first
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
        S_PARITY: begin
          par_d   = din;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (din && (^{shift_q, par_q})) begin
            if (shift_q == 8'hF0) begin
              break_pend_d = 1'b1;
            end else if (shift_q != 8'hE0) begin
              push_req     = 1'b1;
              break_pend_d = 1'b0;  // consumed even if the FIFO drops the entry
            end
          end else begin
            err_inc = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        state_d   = S_IDLE;
        tmo_cnt_d = '0;
        err_inc   = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    // FIFO control. A push on a full FIFO still succeeds when a pop happens
    // in the same cycle.
    empty = (count_q == '0);
    full  = (count_q == CNT_FULL);
    pop   = rd_q & ~ps2kb_rd & ~empty;
    push  = push_req & (~full | pop);
    ovf_d = ovf_q | (push_req & full & ~pop);

    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s_q      <= 2'b11;
      dat_s_q      <= 2'b11;
      filt_q       <= 1'b1;
      filt_prev_q  <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      break_pend_q <= 1'b0;
      err_q        <= '0;
      ovf_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      clk_s_q      <= {clk_s_q[0], ps2_clk};
      dat_s_q      <= {dat_s_q[0], ps2_data};
      filt_q       <= filt_d;
      filt_prev_q  <= filt_q;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_cnt_q    <= tmo_cnt_d;
      break_pend_q <= break_pend_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      rd_q         <= ps2kb_rd;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the storage array is not reset; count_q gates its visibility, so
  // stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {break_pend_q, shift_q};
  end

  // Output only depends on registered FIFO state, never on ps2kb_rd.
  assign ps2kb_key = empty ? 10'h000 : {1'b1, mem[rd_ptr_q]};
  assign ps2kb_ovf = ovf_q;
  assign ps2kb_err = err_q;

endmodule

// File: tb/tb_ps2kb_responder.sv
// Self-checking bench for ps2kb_responder: a directed vector table, hand
// sequences for overflow, timeout, reset and glitch handling, and a random
// phase compared against a queue-based reference model.
module tb_ps2kb_responder;

  localparam int TIMEOUT_CYC = 20000;
  localparam int HALF        = 10;   // clk cycles per PS/2 clock half period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ps2kb_rd = 1'b0;
  logic [9:0] ps2kb_key;
  logic       ps2kb_ovf;
  logic [7:0] ps2kb_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [8:0] mq[$];
  logic       m_pend;
  int         m_err;
  logic       m_ovf;

  ps2kb_responder #(.FIFO_AW(3), .FILTER_LEN(4), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2kb_rd  (ps2kb_rd),
    .ps2kb_key (ps2kb_key),
    .ps2kb_ovf (ps2kb_ovf),
    .ps2kb_err (ps2kb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_read;
    logic [7:0] data;
    bit         bad_par;
    bit         stop;
    logic [9:0] exp_key;
    logic [7:0] exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] m_key();
    return (mq.size() != 0) ? {1'b1, mq[0]} : 10'h000;
  endfunction

  task automatic m_frame(input logic [7:0] d, input bit ok);
    if (!ok) begin
      if (m_err < 255) m_err++;
    end else if (d == 8'hF0) begin
      m_pend = 1'b1;
    end else if (d != 8'hE0) begin
      if (mq.size() < 8) mq.push_back({m_pend, d});
      else               m_ovf = 1'b1;
      m_pend = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_key"}, 32'(ps2kb_key), 32'(m_key()));
    check({tag, "_err"}, 32'(ps2kb_err), 32'(m_err));
    check({tag, "_ovf"}, 32'(ps2kb_ovf), 32'(m_ovf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    ps2kb_rd = 1'b0;
    mq.delete();
    m_pend = 1'b0;
    m_err = 0;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Drives the first nbits of a frame (bit 0 = start) device-style: data
  // changes while the clock is high, the host samples on the falling edge.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    logic par;
    par = (~^d) ^ bad_par;
    send_bits({stop, par, d, 1'b0}, 11);
    m_frame(d, stop && !bad_par);
  endtask

  // One read access; the key must be stable while the strobe is high.
  task automatic do_read(input logic [9:0] exp_during);
    @(negedge clk);
    ps2kb_rd = 1'b1;
    repeat (3) @(negedge clk);
    check("rd_stable", 32'(ps2kb_key), 32'(exp_during));
    ps2kb_rd = 1'b0;
    repeat (2) @(negedge clk);
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  vec_t tbl[12];

  initial begin
    logic [9:0] prev_key;

    tbl[0]  = '{1'b0, 8'h1C, 1'b0, 1'b1, 10'h21C, 8'd0};
    tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b1, 10'h000, 8'd0};
    tbl[2]  = '{1'b0, 8'hF0, 1'b0, 1'b1, 10'h000, 8'd0};
    tbl[3]  = '{1'b0, 8'h1C, 1'b0, 1'b1, 10'h31C, 8'd0};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 10'h000, 8'd0};
    tbl[5]  = '{1'b0, 8'h1C, 1'b0, 1'b1, 10'h21C, 8'd0};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 10'h000, 8'd0};
    tbl[7]  = '{1'b0, 8'h1C, 1'b1, 1'b1, 10'h000, 8'd1};
    tbl[8]  = '{1'b0, 8'h1C, 1'b0, 1'b0, 10'h000, 8'd2};
    tbl[9]  = '{1'b0, 8'hE0, 1'b0, 1'b1, 10'h000, 8'd2};
    tbl[10] = '{1'b0, 8'h55, 1'b0, 1'b1, 10'h255, 8'd2};
    tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b1, 10'h000, 8'd2};

    // Reset state
    do_reset();
    check("reset_key", 32'(ps2kb_key), 32'h000);
    check("reset_err", 32'(ps2kb_err), 32'h00);
    check("reset_ovf", 32'(ps2kb_ovf), 32'h0);

    // Directed vector table: basic frame, read, break prefix, errors, E0
    prev_key = 10'h000;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_read) do_read(prev_key);
      else                send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].stop);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_key", i), 32'(ps2kb_key), 32'(tbl[i].exp_key));
      check($sformatf("vec%0d_err", i), 32'(ps2kb_err), 32'(tbl[i].exp_err));
      prev_key = tbl[i].exp_key;
    end

    // Overflow: nine frames into an eight-entry FIFO, then drain
    do_reset();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf_flag", 32'(ps2kb_ovf), 32'h1);
    check("ovf_head", 32'(ps2kb_key), 32'h201);
    for (int i = 1; i <= 8; i++) do_read(10'h200 | 10'(i));
    check("ovf_drained", 32'(ps2kb_key), 32'h000);
    check("ovf_sticky", 32'(ps2kb_ovf), 32'h1);

    // Timeout: start + 4 data bits then silence
    do_reset();
    check("ovf_cleared", 32'(ps2kb_ovf), 32'h0);
    send_bits(11'b000_0000_1010, 5);
    repeat (TIMEOUT_CYC - 100) @(negedge clk);
    check("tmo_before", 32'(ps2kb_err), 32'h00);
    repeat (120) @(negedge clk);
    check("tmo_err", 32'(ps2kb_err), 32'h01);
    check("tmo_key", 32'(ps2kb_key), 32'h000);
    send_frame(8'h2A, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("tmo_next", 32'(ps2kb_key), 32'h22A);

    // Reset mid-frame with three queued entries
    do_reset();
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h13, 1'b1, 1'b1);
    send_frame(8'h14, 1'b0, 1'b1);
    check("pre_rst_key", 32'(ps2kb_key), 32'h211);
    send_bits(11'b000_0110_0100, 3);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_key", 32'(ps2kb_key), 32'h000);
    check("rst_mid_err", 32'(ps2kb_err), 32'h00);
    check("rst_mid_ovf", 32'(ps2kb_ovf), 32'h0);
    ps2_clk = 1'b1;
    mq.delete();
    m_pend = 1'b0;
    m_err = 0;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_next", 32'(ps2kb_key), 32'h229);

    // Two-cycle glitch with data low must not start a frame
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    send_frame(8'h3A, 1'b0, 1'b1);
    do_read(10'h229);
    check("glitch_key", 32'(ps2kb_key), 32'h23A);
    check("glitch_err", 32'(ps2kb_err), 32'h00);

    // Random frames and reads against the reference model
    do_reset();
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_read(m_key());
      end else begin
        logic [7:0] d;
        int sel;
        sel = $urandom_range(0, 11);
        d = (sel == 0) ? 8'hF0 : (sel == 1) ? 8'hE0 : 8'($urandom);
        send_frame(d, $urandom_range(0, 9) == 0, $urandom_range(0, 11) != 0);
      end
      repeat (3) @(negedge clk);
      check_model($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
